// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit RISC control sequencer.
// Opcodes, state encoding, operand-source codes, long-op helper.
// Build option: CTRL_STEP_EN adds the single-step STEP state.
package cpu_pkg;

    localparam int DW  = 8;
    localparam int OPW = 4;
    localparam int RAW = 2;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h3;
    localparam logic [3:0] OP_PRE = 4'h4;
    localparam logic [3:0] OP_STO = 4'h5;
    localparam logic [3:0] OP_ADD = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_AND = 4'hA;
    localparam logic [3:0] OP_OR  = 4'hB;
    localparam logic [3:0] OP_NOT = 4'hC;
    localparam logic [3:0] OP_XOR = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_ROM = 2'b01;
    localparam logic [1:0] SRC_RAM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_EXEC,
`ifdef CTRL_STEP_EN
        S_STEP,
`endif
        S_HALT
    } state_t;

    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_LDO) || (op == OP_LDA) ||
               (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode decoder for the control sequencer.
// In: i_op. Out: long flag, src select, EXEC strobe set, HLT flag.
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_is_long,
    output logic [1:0] o_src_sel,
    output logic       o_reg_wr,
    output logic       o_acc_wr,
    output logic       o_ram_rd,
    output logic       o_ram_wr,
    output logic       o_flag_ld,
    output logic       o_pc_ld,
    output logic       o_is_hlt
);

    always_comb begin
        o_is_long = is_long(i_op);
        o_src_sel = SRC_REG;
        o_reg_wr  = 1'b0;
        o_acc_wr  = 1'b0;
        o_ram_rd  = 1'b0;
        o_ram_wr  = 1'b0;
        o_flag_ld = 1'b0;
        o_pc_ld   = 1'b0;
        o_is_hlt  = 1'b0;
        unique case (i_op)
            OP_LDO: begin
                o_src_sel = SRC_ROM;
                o_reg_wr  = 1'b1;
            end
            OP_LDA: begin
                o_src_sel = SRC_RAM;
                o_ram_rd  = 1'b1;
                o_reg_wr  = 1'b1;
            end
            OP_LDR: o_reg_wr = 1'b1;
            OP_PRE: o_acc_wr = 1'b1;
            OP_STO: o_ram_wr = 1'b1;
            OP_ADD, OP_SUB, OP_INC, OP_DEC,
            OP_AND, OP_OR, OP_NOT, OP_XOR: begin
                o_acc_wr  = 1'b1;
                o_flag_ld = 1'b1;
            end
            OP_JMP: o_pc_ld  = 1'b1;
            OP_HLT: o_is_hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Control sequencer: fetch, decode, optional operand fetch, execute.
// In: clk, rst_n, run, rom_data, step. Out: ALU op, datapath strobes,
// instr_done, halted. Option CTRL_STEP_EN adds a single-step state.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OPW = 4,
    parameter int RAW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [DW-1:0]  rom_data,
    input  logic           step,
    output logic [OPW-1:0] alu_op,
    output logic [RAW-1:0] reg_addr,
    output logic [DW-1:0]  opnd,
    output logic [1:0]     src_sel,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           rom_rd,
    output logic           ram_rd,
    output logic           ram_wr,
    output logic           reg_wr,
    output logic           acc_wr,
    output logic           flag_ld,
    output logic           instr_done,
    output logic           halted
);

    state_t          r_state;
    logic [DW-1:0]   r_ir;
    logic [DW-1:0]   r_opnd;
    logic [1:0]      r_src_sel;
    logic            r_pc_inc;
    logic            r_pc_ld;
    logic            r_rom_rd;
    logic            r_ram_rd;
    logic            r_ram_wr;
    logic            r_reg_wr;
    logic            r_acc_wr;
    logic            r_flag_ld;
    logic            r_done;
    logic            r_halted;

    logic [OPW-1:0]  w_op;
    logic            w_long;
    logic [1:0]      w_src_sel;
    logic            w_reg_wr;
    logic            w_acc_wr;
    logic            w_ram_rd;
    logic            w_ram_wr;
    logic            w_flag_ld;
    logic            w_pc_ld;
    logic            w_hlt;
    logic            w_go_exec;
    logic            w_go_fetch;
    logic            w_unused_step;

    assign w_op = r_ir[DW-1 -: OPW];

    cpu_op_decode u_dec (
        .i_op      (w_op),
        .o_is_long (w_long),
        .o_src_sel (w_src_sel),
        .o_reg_wr  (w_reg_wr),
        .o_acc_wr  (w_acc_wr),
        .o_ram_rd  (w_ram_rd),
        .o_ram_wr  (w_ram_wr),
        .o_flag_ld (w_flag_ld),
        .o_pc_ld   (w_pc_ld),
        .o_is_hlt  (w_hlt)
    );

    // Strobes are registered one state ahead: these flags mark the
    // transitions that enter EXEC or FETCH so their strobes land there.
    assign w_go_exec = (r_state == S_OPND) ||
                       (r_state == S_DECODE && !w_long);

`ifdef CTRL_STEP_EN
    assign w_go_fetch = run && ((r_state == S_IDLE) ||
                                (r_state == S_STEP && step));
    assign w_unused_step = 1'b0;
`else
    assign w_go_fetch = run && ((r_state == S_IDLE) ||
                                (r_state == S_EXEC && !w_hlt));
    assign w_unused_step = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_opnd    <= '0;
            r_src_sel <= SRC_REG;
            r_pc_inc  <= 1'b0;
            r_pc_ld   <= 1'b0;
            r_rom_rd  <= 1'b0;
            r_ram_rd  <= 1'b0;
            r_ram_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_acc_wr  <= 1'b0;
            r_flag_ld <= 1'b0;
            r_done    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_src_sel <= SRC_REG;
            r_pc_inc  <= 1'b0;
            r_pc_ld   <= 1'b0;
            r_rom_rd  <= 1'b0;
            r_ram_rd  <= 1'b0;
            r_ram_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_acc_wr  <= 1'b0;
            r_flag_ld <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_ir    <= rom_data;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_long) begin
                        r_state  <= S_OPND;
                        r_rom_rd <= 1'b1;
                        r_pc_inc <= 1'b1;
                    end else begin
                        r_state  <= S_EXEC;
                    end
                end
                S_OPND: begin
                    r_opnd  <= rom_data;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_hlt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
`ifdef CTRL_STEP_EN
                        r_state <= S_STEP;
`else
                        r_state <= run ? S_FETCH : S_IDLE;
`endif
                    end
                end
`ifdef CTRL_STEP_EN
                S_STEP: begin
                    if (step) r_state <= run ? S_FETCH : S_IDLE;
                end
`endif
                S_HALT: r_halted <= 1'b1;
                default: r_state <= S_IDLE;
            endcase
            if (w_go_fetch) begin
                r_rom_rd <= 1'b1;
                r_pc_inc <= 1'b1;
            end
            if (w_go_exec) begin
                r_src_sel <= w_src_sel;
                r_rom_rd  <= (w_src_sel == SRC_ROM);
                r_ram_rd  <= w_ram_rd;
                r_ram_wr  <= w_ram_wr;
                r_reg_wr  <= w_reg_wr;
                r_acc_wr  <= w_acc_wr;
                r_flag_ld <= w_flag_ld;
                r_pc_ld   <= w_pc_ld;
                r_done    <= 1'b1;
            end
        end
    end

    assign alu_op     = w_op;
    assign reg_addr   = r_ir[RAW-1:0];
    assign opnd       = r_opnd;
    assign src_sel    = r_src_sel;
    assign pc_inc     = r_pc_inc;
    assign pc_ld      = r_pc_ld;
    assign rom_rd     = r_rom_rd;
    assign ram_rd     = r_ram_rd;
    assign ram_wr     = r_ram_wr;
    assign reg_wr     = r_reg_wr;
    assign acc_wr     = r_acc_wr;
    assign flag_ld    = r_flag_ld;
    assign instr_done = r_done;
    assign halted     = r_halted;

endmodule
